// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared types and constants for the instruction memory
package riscv_defines;

    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [WORD_WIDTH-1:0] data;
    } instr_rsp_t;

    typedef enum logic {
        IMEM_CLEAR,
        IMEM_RUN
    } imem_state_e;

    // 33-bit arithmetic so an address near 2^32 never wraps back into the window
    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] span
    );
        logic [32:0] offset;
        offset = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (offset < span);
    endfunction

endpackage

// File: rtl/instr_mem_rsp_pipe.sv
// rtl/instr_mem_rsp_pipe.sv - fixed-latency response shift register for fetch replies
module instr_mem_rsp_pipe
    import riscv_defines::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  instr_rsp_t            rsp_i,
    output logic                  rvalid_o,
    output logic                  err_o,
    output logic [WORD_WIDTH-1:0] rdata_o
);

    instr_rsp_t stage_q [LATENCY];

    // Shift responses forward; payload only moves with a valid beat so the
    // last stage holds its data and err through idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(LATENCY); k++) begin
                stage_q[k].valid <= 1'b0;
            end
            stage_q[LATENCY-1].err  <= 1'b0;
            stage_q[LATENCY-1].data <= '0;
        end else begin
            stage_q[0].valid <= rsp_i.valid;
            if (rsp_i.valid) begin
                stage_q[0].err  <= rsp_i.err;
                stage_q[0].data <= rsp_i.data;
            end
            for (int k = 1; k < int'(LATENCY); k++) begin
                stage_q[k].valid <= stage_q[k-1].valid;
                if (stage_q[k-1].valid) begin
                    stage_q[k].err  <= stage_q[k-1].err;
                    stage_q[k].data <= stage_q[k-1].data;
                end
            end
        end
    end

    assign rvalid_o = stage_q[LATENCY-1].valid;
    assign err_o    = stage_q[LATENCY-1].err;
    assign rdata_o  = stage_q[LATENCY-1].data;

endmodule

// File: rtl/instr_mem_pipelined.sv
// rtl/instr_mem_pipelined.sv - instruction RAM with program-load port and pipelined fetch
module instr_mem_pipelined
    import riscv_defines::*;
#(
    parameter int unsigned DEPTH_WORDS  = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        prog_we_i,
    input  logic [31:0] prog_addr_i,
    input  logic [31:0] prog_wdata_i,
    input  logic [3:0]  prog_be_i,
    output logic        ready_o
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    imem_state_e           state_q;
    logic [AW-1:0]         clr_idx_q;
    logic                  ready_q;
    logic [WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic          fetch_in_range;
    logic          prog_in_range;
    logic [AW-1:0] fetch_idx;
    logic [AW-1:0] prog_idx;
    logic          running;
    logic          clr_we;
    logic          prog_en;
    instr_rsp_t    rsp_d;

    assign running        = !rst && (state_q == IMEM_RUN);
    assign fetch_in_range = addr_in_range(instr_addr_i, BASE_ADDR, SPAN);
    assign prog_in_range  = addr_in_range(prog_addr_i, BASE_ADDR, SPAN);
    assign fetch_idx      = AW'((instr_addr_i - BASE_ADDR) >> 2);
    assign prog_idx       = AW'((prog_addr_i - BASE_ADDR) >> 2);

    // A load write owns the cycle; a fetch in the same cycle simply stalls
    assign instr_gnt_o = running && instr_req_i && !prog_we_i;
    assign clr_we      = !rst && (state_q == IMEM_CLEAR);
    assign prog_en     = running && prog_we_i && prog_in_range;
    assign ready_o     = ready_q;

    // Build the response beat for this cycle's grant from the array read
    always_comb begin
        rsp_d       = '0;
        rsp_d.valid = instr_gnt_o;
        rsp_d.err   = !fetch_in_range;
        rsp_d.data  = fetch_in_range ? mem_q[fetch_idx] : NOP_INSTR;
    end

    // Control FSM: sweep the clear counter once after reset, then serve traffic
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RST ? IMEM_CLEAR : IMEM_RUN;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                IMEM_CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == LAST_IDX) begin
                        state_q <= IMEM_RUN;
                        ready_q <= 1'b1;
                    end
                end
                IMEM_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IMEM_CLEAR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: clear sweep or byte-enabled program load, never both
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_idx_q] <= '0;
        end else if (prog_en) begin
            for (int b = 0; b < 4; b++) begin
                if (prog_be_i[b]) begin
                    mem_q[prog_idx][8*b +: 8] <= prog_wdata_i[8*b +: 8];
                end
            end
        end
    end

    instr_mem_rsp_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_rsp_pipe (
        .clk      (clk),
        .rst      (rst),
        .rsp_i    (rsp_d),
        .rvalid_o (instr_rvalid_o),
        .err_o    (instr_err_o),
        .rdata_o  (instr_rdata_o)
    );

endmodule
